// File: rtl/branch_issue_queue_if.sv
// Dispatch / writeback / issue bundle of the branch issue queue.
// The queue takes the slave view; dispatch and the bench take the master view.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 5
`endif

interface branch_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int SID_W = `SCOREBOARD_SIZE_WIDTH
);
  logic                     enq_valid;
  logic                     enq_ready;
  logic [63:0]              enq_pc;
  logic [31:0]              enq_inst;
  logic [SID_W-1:0]         enq_sid;
  logic [3:0]               enq_func_code;
  logic                     enq_rs1_rdy;
  logic [SID_W-1:0]         enq_rs1_tag;
  logic [63:0]              enq_rs1_value;
  logic                     enq_rs2_rdy;
  logic [SID_W-1:0]         enq_rs2_tag;
  logic [63:0]              enq_rs2_value;
  logic                     wb_valid;
  logic [SID_W-1:0]         wb_tag;
  logic [63:0]              wb_value;
  logic                     issue_valid;
  logic [63:0]              issue_pc;
  logic [31:0]              issue_inst;
  logic [SID_W-1:0]         issue_sid;
  logic [3:0]               issue_func_code;
  logic [63:0]              issue_rs1_value;
  logic [63:0]              issue_rs2_value;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output enq_valid, enq_pc, enq_inst, enq_sid, enq_func_code,
           enq_rs1_rdy, enq_rs1_tag, enq_rs1_value,
           enq_rs2_rdy, enq_rs2_tag, enq_rs2_value,
           wb_valid, wb_tag, wb_value,
    input  enq_ready, issue_valid, issue_pc, issue_inst, issue_sid, issue_func_code,
           issue_rs1_value, issue_rs2_value, count
  );

  modport slave (
    input  enq_valid, enq_pc, enq_inst, enq_sid, enq_func_code,
           enq_rs1_rdy, enq_rs1_tag, enq_rs1_value,
           enq_rs2_rdy, enq_rs2_tag, enq_rs2_value,
           wb_valid, wb_tag, wb_value,
    output enq_ready, issue_valid, issue_pc, issue_inst, issue_sid, issue_func_code,
           issue_rs1_value, issue_rs2_value, count
  );
endinterface

// File: rtl/branch_issue_queue.sv
// In-order branch issue queue: ring buffer of decoded branch ops that snoops the
// writeback bus for pending operands and issues the head once both are ready.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 5
`endif

module branch_issue_queue #(
  parameter int DEPTH = 4,
  parameter int SID_W = `SCOREBOARD_SIZE_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  branch_issue_queue_if.slave bq
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [63:0]      pc;
    logic [31:0]      inst;
    logic [SID_W-1:0] sid;
    logic [3:0]       fc;
    logic             rs1_rdy;
    logic [SID_W-1:0] rs1_tag;
    logic [63:0]      rs1_val;
    logic             rs2_rdy;
    logic [SID_W-1:0] rs2_tag;
    logic [63:0]      rs2_val;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q;
  logic   [DEPTH-1:0] vld_q, vld_d;
  logic   [PW:0]      head_q, head_d, tail_q, tail_d;
  logic   [PW-1:0]    hidx, tidx;
  logic               full, enq_fire, iss_fire;
  entry_t             head_ent, enq_ent;

  always_comb begin
    hidx     = head_q[PW-1:0];
    tidx     = tail_q[PW-1:0];
    full     = (head_q[PW] != tail_q[PW]) && (hidx == tidx);
    head_ent = ent_q[hidx];
    enq_fire = bq.enq_valid & ~full & ~flush_i;
    iss_fire = vld_q[hidx] & head_ent.rs1_rdy & head_ent.rs2_rdy & ~flush_i;
  end

  // Incoming op picks up a same-cycle broadcast so it never misses its producer.
  always_comb begin
    enq_ent         = '0;
    enq_ent.pc      = bq.enq_pc;
    enq_ent.inst    = bq.enq_inst;
    enq_ent.sid     = bq.enq_sid;
    enq_ent.fc      = bq.enq_func_code;
    enq_ent.rs1_tag = bq.enq_rs1_tag;
    enq_ent.rs2_tag = bq.enq_rs2_tag;
    enq_ent.rs1_rdy = bq.enq_rs1_rdy | (bq.wb_valid & (bq.enq_rs1_tag == bq.wb_tag));
    enq_ent.rs2_rdy = bq.enq_rs2_rdy | (bq.wb_valid & (bq.enq_rs2_tag == bq.wb_tag));
    enq_ent.rs1_val = bq.enq_rs1_rdy ? bq.enq_rs1_value : bq.wb_value;
    enq_ent.rs2_val = bq.enq_rs2_rdy ? bq.enq_rs2_value : bq.wb_value;
  end

  always_comb begin
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      vld_d  = '0;
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq_fire) begin
        vld_d[tidx] = 1'b1;
        tail_d      = tail_q + (PW+1)'(1);
      end
      if (iss_fire) begin
        vld_d[hidx] = 1'b0;
        head_d      = head_q + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Payload has no reset; vld_q alone decides whether a slot means anything.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_fire && tidx == PW'(i)) begin
        ent_q[i] <= enq_ent;
      end else if (vld_q[i] && bq.wb_valid) begin
        if (!ent_q[i].rs1_rdy && ent_q[i].rs1_tag == bq.wb_tag) begin
          ent_q[i].rs1_rdy <= 1'b1;
          ent_q[i].rs1_val <= bq.wb_value;
        end
        if (!ent_q[i].rs2_rdy && ent_q[i].rs2_tag == bq.wb_tag) begin
          ent_q[i].rs2_rdy <= 1'b1;
          ent_q[i].rs2_val <= bq.wb_value;
        end
      end
    end
  end

  assign bq.enq_ready       = ~full;
  assign bq.issue_valid     = iss_fire;
  assign bq.issue_pc        = head_ent.pc;
  assign bq.issue_inst      = head_ent.inst;
  assign bq.issue_sid       = head_ent.sid;
  assign bq.issue_func_code = head_ent.fc;
  assign bq.issue_rs1_value = head_ent.rs1_val;
  assign bq.issue_rs2_value = head_ent.rs2_val;
  assign bq.count           = tail_q - head_q;
endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed bench for branch_issue_queue: a queue-based model checked every cycle,
// plus hand-computed literal expectations and a final issue-order log check.
module tb_branch_issue_queue;
  localparam int DEPTH = 4;
  localparam int SID_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  branch_issue_queue_if #(.DEPTH(DEPTH), .SID_W(SID_W)) bus();

  branch_issue_queue #(.DEPTH(DEPTH), .SID_W(SID_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .bq(bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  sid;
    logic [3:0]  fc;
    bit          r1rdy;
    logic [4:0]  r1tag;
    logic [63:0] r1val;
    bit          r2rdy;
    logic [4:0]  r2tag;
    logic [63:0] r2val;
  } m_t;

  m_t          mq[$];
  logic [63:0] log_pc[$];
  bit          live = 1'b0;

  // Model: a plain FIFO of ops; compare outputs, then apply this edge's events.
  always @(negedge clk) begin
    m_t e;
    bit exp_iv;
    bit room;
    exp_iv = 1'b0;
    if (live) begin
      exp_iv = mq.size() > 0 && mq[0].r1rdy && mq[0].r2rdy && !flush;
      chk("count", 64'(bus.count), 64'(mq.size()));
      chk("enq_ready", 64'(bus.enq_ready), 64'(mq.size() < DEPTH));
      chk("issue_valid", 64'(bus.issue_valid), 64'(exp_iv));
      if (exp_iv) begin
        chk("issue_pc", bus.issue_pc, mq[0].pc);
        chk("issue_inst", 64'(bus.issue_inst), 64'(mq[0].inst));
        chk("issue_sid", 64'(bus.issue_sid), 64'(mq[0].sid));
        chk("issue_fc", 64'(bus.issue_func_code), 64'(mq[0].fc));
        chk("issue_rs1", bus.issue_rs1_value, mq[0].r1val);
        chk("issue_rs2", bus.issue_rs2_value, mq[0].r2val);
      end
    end
    if (bus.issue_valid === 1'b1) log_pc.push_back(bus.issue_pc);
    if (!rst_n) begin
      mq.delete();
      live = 1'b1;
    end else if (live) begin
      if (flush) mq.delete();
      else begin
        room = mq.size() < DEPTH;
        if (exp_iv) void'(mq.pop_front());
        if (bus.wb_valid) begin
          foreach (mq[i]) begin
            if (!mq[i].r1rdy && mq[i].r1tag == bus.wb_tag) begin
              mq[i].r1rdy = 1'b1; mq[i].r1val = bus.wb_value;
            end
            if (!mq[i].r2rdy && mq[i].r2tag == bus.wb_tag) begin
              mq[i].r2rdy = 1'b1; mq[i].r2val = bus.wb_value;
            end
          end
        end
        if (bus.enq_valid && room) begin
          e.pc = bus.enq_pc; e.inst = bus.enq_inst; e.sid = bus.enq_sid;
          e.fc = bus.enq_func_code;
          e.r1rdy = bus.enq_rs1_rdy; e.r1tag = bus.enq_rs1_tag; e.r1val = bus.enq_rs1_value;
          e.r2rdy = bus.enq_rs2_rdy; e.r2tag = bus.enq_rs2_tag; e.r2val = bus.enq_rs2_value;
          if (bus.wb_valid && !e.r1rdy && e.r1tag == bus.wb_tag) begin
            e.r1rdy = 1'b1; e.r1val = bus.wb_value;
          end
          if (bus.wb_valid && !e.r2rdy && e.r2tag == bus.wb_tag) begin
            e.r2rdy = 1'b1; e.r2val = bus.wb_value;
          end
          mq.push_back(e);
        end
      end
    end
  end

  task automatic idle();
    bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_inst = '0; bus.enq_sid = '0;
    bus.enq_func_code = '0;
    bus.enq_rs1_rdy = 1'b0; bus.enq_rs1_tag = '0; bus.enq_rs1_value = '0;
    bus.enq_rs2_rdy = 1'b0; bus.enq_rs2_tag = '0; bus.enq_rs2_value = '0;
    bus.wb_valid = 1'b0; bus.wb_tag = '0; bus.wb_value = '0;
    flush = 1'b0;
  endtask

  task automatic enq(input logic [63:0] pc, input logic [3:0] fc,
                     input bit r1rdy, input logic [4:0] r1tag, input logic [63:0] r1v,
                     input bit r2rdy, input logic [4:0] r2tag, input logic [63:0] r2v);
    bus.enq_valid = 1'b1; bus.enq_pc = pc; bus.enq_inst = pc[31:0] ^ 32'h0000_0063;
    bus.enq_sid = pc[8:4]; bus.enq_func_code = fc;
    bus.enq_rs1_rdy = r1rdy; bus.enq_rs1_tag = r1tag; bus.enq_rs1_value = r1v;
    bus.enq_rs2_rdy = r2rdy; bus.enq_rs2_tag = r2tag; bus.enq_rs2_value = r2v;
  endtask

  task automatic wb(input logic [4:0] tag, input logic [63:0] val);
    bus.wb_valid = 1'b1; bus.wb_tag = tag; bus.wb_value = val;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] exp_log[$];

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset count", 64'(bus.count), 64'd0);
    chk("reset enq_ready", 64'(bus.enq_ready), 64'd1);
    chk("reset issue_valid", 64'(bus.issue_valid), 64'd0);

    // 1: ready jal issues the cycle after enqueue
    enq(64'h1000, 4'b0111, 1, 0, 64'h11, 1, 0, 64'h22);
    tick(); idle();
    chk("t1 issue_valid", 64'(bus.issue_valid), 64'd1);
    chk("t1 issue_pc", bus.issue_pc, 64'h1000);
    chk("t1 count", 64'(bus.count), 64'd1);
    tick();
    chk("t1 count after", 64'(bus.count), 64'd0);

    // 2: rs1 wakeup; unrelated tag ignored
    enq(64'h2000, 4'b0100, 0, 5'd3, 64'h0, 1, 0, 64'h7);
    tick(); idle();
    wb(5'd2, 64'h99); #1;
    chk("t2 wait0", 64'(bus.issue_valid), 64'd0);
    tick(); idle();
    wb(5'd3, 64'h55); #1;
    chk("t2 wait1", 64'(bus.issue_valid), 64'd0);
    tick(); idle();
    chk("t2 issue_valid", 64'(bus.issue_valid), 64'd1);
    chk("t2 rs1", bus.issue_rs1_value, 64'h55);
    chk("t2 rs2", bus.issue_rs2_value, 64'h7);
    tick();

    // 3: blocked head, full queue, dropped enqueue, then drain in order
    enq(64'h3000, 4'b0100, 0, 5'd5, 64'h0, 1, 0, 64'h1);  tick();
    enq(64'h3010, 4'b0101, 1, 0, 64'h10, 1, 0, 64'h0);    tick();
    enq(64'h3020, 4'b0100, 1, 0, 64'h20, 1, 0, 64'h21);   tick();
    enq(64'h3030, 4'b0111, 1, 0, 64'h30, 1, 0, 64'h31);   tick();
    enq(64'h3040, 4'b0111, 1, 0, 64'h40, 1, 0, 64'h41);
    wb(5'd5, 64'h5A); #1;
    chk("t3 full count", 64'(bus.count), 64'd4);
    chk("t3 full enq_ready", 64'(bus.enq_ready), 64'd0);
    tick(); idle();
    chk("t3 count after drop", 64'(bus.count), 64'd4);
    chk("t3 head rs1", bus.issue_rs1_value, 64'h5A);
    for (int k = 0; k < 4; k++) begin
      chk("t3 drain valid", 64'(bus.issue_valid), 64'd1);
      chk("t3 drain pc", bus.issue_pc, 64'h3000 + 64'(k) * 64'h10);
      tick();
    end
    chk("t3 empty", 64'(bus.count), 64'd0);

    // 4: same-cycle bypass on enqueue
    enq(64'h4000, 4'b0100, 1, 0, 64'h1, 0, 5'd9, 64'h0);
    wb(5'd9, 64'hAA);
    tick(); idle();
    chk("t4 issue_valid", 64'(bus.issue_valid), 64'd1);
    chk("t4 rs2 bypass", bus.issue_rs2_value, 64'hAA);
    tick();

    // 5: flush with concurrent enqueue, then reset mid-operation
    enq(64'h5000, 4'b0100, 0, 5'd7, 64'h0, 1, 0, 64'h2);  tick();
    enq(64'h5010, 4'b0100, 1, 0, 64'h3, 1, 0, 64'h4);     tick();
    enq(64'h5020, 4'b0100, 1, 0, 64'h5, 1, 0, 64'h6);     tick();
    idle(); wb(5'd7, 64'h77); tick(); idle();
    flush = 1'b1;
    enq(64'h5030, 4'b0111, 1, 0, 64'h8, 1, 0, 64'h9); #1;
    chk("t5 flush count", 64'(bus.count), 64'd3);
    chk("t5 flush issue_valid", 64'(bus.issue_valid), 64'd0);
    tick(); idle();
    chk("t5 count after flush", 64'(bus.count), 64'd0);
    chk("t5 ready after flush", 64'(bus.enq_ready), 64'd1);
    tick();
    enq(64'h5040, 4'b0100, 0, 5'd8, 64'h0, 1, 0, 64'h1);  tick();
    enq(64'h5050, 4'b0100, 1, 0, 64'h1, 1, 0, 64'h1);     tick();
    idle(); rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5 rst count", 64'(bus.count), 64'd0);
    chk("t5 rst ready", 64'(bus.enq_ready), 64'd1);
    chk("t5 rst issue_valid", 64'(bus.issue_valid), 64'd0);
    enq(64'h5100, 4'b0111, 1, 0, 64'hB, 1, 0, 64'hC);
    tick(); idle();
    chk("t5 post-reset pc", bus.issue_pc, 64'h5100);
    tick();

    // 6: twelve back-to-back ops, pointers wrap three times
    for (int k = 0; k < 12; k++) begin
      enq(64'h6000 + 64'(k) * 64'h10, 4'b0111, 1, 0, 64'(k), 1, 0, 64'(k + 100));
      tick();
    end
    idle(); tick(); tick();
    chk("t6 count", 64'(bus.count), 64'd0);

    exp_log = '{64'h1000, 64'h2000, 64'h3000, 64'h3010, 64'h3020, 64'h3030, 64'h4000, 64'h5100};
    for (int k = 0; k < 12; k++) exp_log.push_back(64'h6000 + 64'(k) * 64'h10);
    chk("issue log size", 64'(log_pc.size()), 64'(exp_log.size()));
    for (int k = 0; k < exp_log.size() && k < log_pc.size(); k++)
      chk("issue log order", log_pc[k], exp_log[k]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
